// File: rtl/acc_window_sequencer.sv
// Conv-window accumulator sequencer: strobes products into the accumulator and hands each window sum downstream.
// Optional build macro ACC_SEQ_RELU_EN clamps negative window sums to zero at capture.
module acc_window_sequencer #(
  parameter int DATA_WIDTH  = 20,
  parameter int KERNEL_SIZE = 3,
  localparam int TAPS       = KERNEL_SIZE * KERNEL_SIZE,
  localparam int TAP_W      = $clog2(TAPS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  input  logic [DATA_WIDTH-1:0] prod_data,
  output logic                  acc_en,
  output logic                  acc_load,
  output logic [DATA_WIDTH-1:0] acc_data,
  input  logic [DATA_WIDTH-1:0] acc_sum,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [TAP_W-1:0]      tap_idx,
  output logic                  busy
);

  // state   | meaning
  // ACCUM   | accepting products, strobing them into the accumulator
  // DRAIN   | accumulator absorbs the last tap's strobe
  // CAPTURE | acc_sum is final; register it as the window result
  // OUTPUT  | result presented, waiting for res_ready
  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    DRAIN   = 2'd1,
    CAPTURE = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic                  accept;
  logic                  first_tap;
  logic                  last_tap;
  logic [DATA_WIDTH-1:0] capture_val;

  assign accept    = prod_valid && prod_ready;
  assign first_tap = (tap_idx == '0);
  assign last_tap  = (tap_idx == TAP_W'(TAPS - 1));
  assign busy      = (tap_idx != '0) || (state != ACCUM);

`ifdef ACC_SEQ_RELU_EN
  assign capture_val = acc_sum[DATA_WIDTH-1] ? '0 : acc_sum;
`else
  assign capture_val = acc_sum;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ACCUM;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    prod_ready = 1'b0;
    case (state)
      ACCUM: begin
        prod_ready = 1'b1;
        if (accept && last_tap) state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = OUTPUT;
      OUTPUT:  if (res_valid && res_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Strobes are registered so the accumulator sees a clean one-cycle pulse per accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_en   <= 1'b0;
      acc_load <= 1'b0;
      acc_data <= '0;
      tap_idx  <= '0;
    end else if (accept) begin
      acc_en   <= 1'b1;
      acc_load <= first_tap;
      acc_data <= prod_data;
      tap_idx  <= last_tap ? '0 : tap_idx + TAP_W'(1);
    end else begin
      acc_en   <= 1'b0;
      acc_load <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
    end else if (state == CAPTURE) begin
      res_valid <= 1'b1;
      res_data  <= capture_val;
    end else if (state == OUTPUT && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_window_sequencer.sv
// Directed bench for acc_window_sequencer: 3x3 and 1x1 kernel instances, each driving a behavioural accumulator.
module tb_acc_window_sequencer;

  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  int            checks = 0;
  int            errors = 0;

  logic          prod_valid = 1'b0, prod_ready;
  logic [DW-1:0] prod_data = '0;
  logic          acc_en, acc_load;
  logic [DW-1:0] acc_data, acc_sum = '0;
  logic          res_valid, res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic [3:0]    tap_idx;
  logic          busy;

  logic          p1_valid = 1'b0, p1_ready;
  logic [DW-1:0] p1_data = '0;
  logic          a1_en, a1_load;
  logic [DW-1:0] a1_data, a1_sum = '0;
  logic          r1_valid, r1_ready = 1'b0;
  logic [DW-1:0] r1_data;
  logic [0:0]    t1_idx;
  logic          b1_busy;

  acc_window_sequencer #(.DATA_WIDTH(DW), .KERNEL_SIZE(3)) dut (
    .clk(clk), .rst(rst),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data),
    .acc_en(acc_en), .acc_load(acc_load), .acc_data(acc_data), .acc_sum(acc_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .tap_idx(tap_idx), .busy(busy)
  );

  acc_window_sequencer #(.DATA_WIDTH(DW), .KERNEL_SIZE(1)) dut1 (
    .clk(clk), .rst(rst),
    .prod_valid(p1_valid), .prod_ready(p1_ready), .prod_data(p1_data),
    .acc_en(a1_en), .acc_load(a1_load), .acc_data(a1_data), .acc_sum(a1_sum),
    .res_valid(r1_valid), .res_ready(r1_ready), .res_data(r1_data),
    .tap_idx(t1_idx), .busy(b1_busy)
  );

  always #5 clk = ~clk;

  // Behavioural accumulators: load or add on the strobe, applied at the next edge.
  always @(posedge clk) begin
    if (acc_en) acc_sum <= acc_load ? acc_data : acc_sum + acc_data;
    if (a1_en)  a1_sum  <= a1_load ? a1_data : a1_sum + a1_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (acc_en !== 1'b0 || acc_load !== 1'b0 || acc_data !== '0) begin
      errors++; $display("FAIL reset_strobes: got en=%b load=%b data=%h required 0 0 0", acc_en, acc_load, acc_data); end
    checks++; if (res_valid !== 1'b0 || res_data !== '0 || tap_idx !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_result: got rv=%b rd=%h tap=%0d busy=%b required 0 0 0 0", res_valid, res_data, tap_idx, busy); end
    checks++; if (prod_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b required 1", prod_ready); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 9; i++) begin
      prod_valid = 1'b1; prod_data = DW'(i);
      step();
      checks++; if (acc_en !== 1'b1 || acc_load !== (i == 1) || acc_data !== DW'(i)) begin
        errors++; $display("FAIL b2b_strobe tap %0d: got en=%b load=%b data=%0d required 1 %b %0d", i, acc_en, acc_load, acc_data, i == 1, i); end
      checks++; if (tap_idx !== 4'(i % 9)) begin
        errors++; $display("FAIL b2b_tap %0d: got %0d required %0d", i, tap_idx, i % 9); end
    end
    prod_data = DW'(99);
    checks++; if (prod_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_drain: got ready=%b busy=%b required 0 1", prod_ready, busy); end
    step();
    checks++; if (res_valid !== 1'b0 || acc_en !== 1'b0) begin
      errors++; $display("FAIL b2b_capture: got rv=%b en=%b required 0 0", res_valid, acc_en); end
    step();
    checks++; if (res_valid !== 1'b1 || res_data !== DW'(45) || prod_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_result: got rv=%b rd=%0d ready=%b required 1 45 0", res_valid, res_data, prod_ready); end
    prod_valid = 1'b0; res_ready = 1'b1;
    step();
    checks++; if (res_valid !== 1'b0 || prod_ready !== 1'b1 || busy !== 1'b0 || acc_en !== 1'b0) begin
      errors++; $display("FAIL b2b_handshake: got rv=%b ready=%b busy=%b en=%b required 0 1 0 0", res_valid, prod_ready, busy, acc_en); end
    res_ready = 1'b0;
  endtask

  task automatic test_gapped_stall();
    for (int i = 1; i <= 9; i++) begin
      prod_valid = 1'b1; prod_data = DW'(i);
      step();
      checks++; if (acc_en !== 1'b1 || acc_load !== (i == 1) || acc_data !== DW'(i)) begin
        errors++; $display("FAIL gap_strobe tap %0d: got en=%b load=%b data=%0d", i, acc_en, acc_load, acc_data); end
      prod_valid = 1'b0; prod_data = DW'(i + 50);
      step();
      checks++; if (acc_en !== 1'b0 || acc_load !== 1'b0 || acc_data !== DW'(i) || tap_idx !== 4'(i % 9)) begin
        errors++; $display("FAIL gap_hold %0d: got en=%b load=%b data=%0d tap=%0d required 0 0 %0d %0d", i, acc_en, acc_load, acc_data, tap_idx, i, i % 9); end
    end
    step();
    prod_valid = 1'b1; prod_data = DW'(77);
    for (int c = 0; c < 5; c++) begin
      checks++; if (res_valid !== 1'b1 || res_data !== DW'(45) || prod_ready !== 1'b0 || acc_en !== 1'b0) begin
        errors++; $display("FAIL stall cycle %0d: got rv=%b rd=%0d ready=%b en=%b required 1 45 0 0", c, res_valid, res_data, prod_ready, acc_en); end
      step();
    end
    prod_valid = 1'b0; res_ready = 1'b1;
    step();
    checks++; if (res_valid !== 1'b0 || tap_idx !== 4'd0 || acc_en !== 1'b0) begin
      errors++; $display("FAIL stall_release: got rv=%b tap=%0d en=%b required 0 0 0", res_valid, tap_idx, acc_en); end
    res_ready = 1'b0;
  endtask

  task automatic test_two_windows();
    logic [DW-1:0] want;
    res_ready = 1'b1;
    for (int w = 0; w < 2; w++) begin
      want = (w == 0) ? DW'(18) : DW'(27);
      for (int i = 0; i < 9; i++) begin
        prod_valid = 1'b1; prod_data = DW'(w + 2);
        step();
        checks++; if (acc_load !== (i == 0)) begin
          errors++; $display("FAIL two_win_load w%0d tap %0d: got %b required %b", w, i, acc_load, i == 0); end
      end
      prod_valid = 1'b0;
      step(); step();
      checks++; if (res_valid !== 1'b1 || res_data !== want) begin
        errors++; $display("FAIL two_win_result w%0d: got rv=%b rd=%0d required 1 %0d", w, res_valid, res_data, want); end
      step();
    end
    res_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      prod_valid = 1'b1; prod_data = DW'(5);
      step();
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (acc_en !== 1'b0 || acc_load !== 1'b0 || acc_data !== '0 || res_data !== '0 || res_valid !== 1'b0 || tap_idx !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset: got en=%b load=%b data=%h rd=%h rv=%b tap=%0d busy=%b required all 0", acc_en, acc_load, acc_data, res_data, res_valid, tap_idx, busy); end
    prod_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    res_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      prod_valid = 1'b1; prod_data = DW'(1);
      step();
      if (i == 0) begin
        checks++; if (acc_load !== 1'b1 || acc_en !== 1'b1) begin
          errors++; $display("FAIL post_reset_load: got load=%b en=%b required 1 1", acc_load, acc_en); end
      end
    end
    prod_valid = 1'b0;
    step(); step();
    checks++; if (res_valid !== 1'b1 || res_data !== DW'(9)) begin
      errors++; $display("FAIL post_reset_result: got rv=%b rd=%0d required 1 9", res_valid, res_data); end
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_relu();
    logic [DW-1:0] want;
`ifdef ACC_SEQ_RELU_EN
    want = '0;
`else
    want = 20'hFFFD3;
`endif
    res_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      prod_valid = 1'b1; prod_data = -DW'(5);
      step();
    end
    prod_valid = 1'b0;
    step(); step();
    checks++; if (res_valid !== 1'b1 || res_data !== want) begin
      errors++; $display("FAIL relu_result: got rv=%b rd=%h required 1 %h", res_valid, res_data, want); end
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_kernel_one();
    logic [DW-1:0] vals [2];
    logic [DW-1:0] want [2];
    vals[0] = DW'(7); vals[1] = 20'hFFFFF;
    want[0] = DW'(7);
`ifdef ACC_SEQ_RELU_EN
    want[1] = '0;
`else
    want[1] = 20'hFFFFF;
`endif
    r1_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      p1_valid = 1'b1; p1_data = vals[k];
      step();
      checks++; if (a1_en !== 1'b1 || a1_load !== 1'b1 || a1_data !== vals[k] || t1_idx !== 1'b0 || p1_ready !== 1'b0) begin
        errors++; $display("FAIL k1_strobe %0d: got en=%b load=%b data=%h tap=%0d ready=%b", k, a1_en, a1_load, a1_data, t1_idx, p1_ready); end
      p1_valid = 1'b0;
      step(); step();
      checks++; if (r1_valid !== 1'b1 || r1_data !== want[k]) begin
        errors++; $display("FAIL k1_result %0d: got rv=%b rd=%h required 1 %h", k, r1_valid, r1_data, want[k]); end
      step();
      checks++; if (r1_valid !== 1'b0 || b1_busy !== 1'b0) begin
        errors++; $display("FAIL k1_release %0d: got rv=%b busy=%b required 0 0", k, r1_valid, b1_busy); end
    end
    r1_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped_stall();
    test_two_windows();
    test_async_reset();
    test_relu();
    test_kernel_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
